// File: rtl/conv_ch_scheduler_pkg.sv
// Shared types and constants for the convolution channel scheduler.
package conv_ch_scheduler_pkg;

    localparam int CH_SCHED_CH_W   = 7;
    localparam int CH_SCHED_PERF_W = 32;

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_LAUNCH,
        CS_WAIT,
        CS_NEXT,
        CS_DRAIN,
        CS_DONE
    } ch_sched_state_e;

endpackage

// File: rtl/conv_ch_scheduler_if.sv
// Scheduler control bus: layer start/abort, feeder start/finished, SA drain, status.
// master drives the _i signals, slave (the scheduler) drives the _o signals.
interface conv_ch_scheduler_if
    import conv_ch_scheduler_pkg::*;
#(
    parameter int CH_W   = CH_SCHED_CH_W,
    parameter int PERF_W = CH_SCHED_PERF_W
);
    logic              start_i;
    logic              abort_i;
    logic [CH_W-1:0]   cfg_num_ch_i;
    logic              inputs_start_o;
    logic              inputs_finished_i;
    logic              weights_start_o;
    logic              weights_finished_i;
    logic [CH_W-1:0]   current_ch_o;
    logic              sa_drain_o;
    logic              sa_drain_done_i;
    logic              busy_o;
    logic              done_o;
    logic [PERF_W-1:0] perf_cycles_o;

    modport master (
        output start_i, abort_i, cfg_num_ch_i, inputs_finished_i,
               weights_finished_i, sa_drain_done_i,
        input  inputs_start_o, weights_start_o, current_ch_o, sa_drain_o,
               busy_o, done_o, perf_cycles_o
    );

    modport slave (
        input  start_i, abort_i, cfg_num_ch_i, inputs_finished_i,
               weights_finished_i, sa_drain_done_i,
        output inputs_start_o, weights_start_o, current_ch_o, sa_drain_o,
               busy_o, done_o, perf_cycles_o
    );
endinterface

// File: rtl/conv_ch_scheduler_perf.sv
// Saturating busy-cycle counter, cleared on layer start.
// Latency: count visible the cycle after the counted cycle.
// Backpressure: none; holds at all-ones once saturated.
module ch_sched_perf_cnt #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/conv_ch_scheduler.sv
// Sequences one conv layer over its input channels, then drains the SA; CH_SCHED_PERF_EN adds a busy counter.
// Latency: start -> first feeder start 1 cycle; both finished -> next feeder start 2 cycles.
// Backpressure: start ignored while busy; waits on feeder finished and drain done, abort wins over all.
module conv_ch_scheduler
    import conv_ch_scheduler_pkg::*;
#(
    parameter int CH_W   = CH_SCHED_CH_W,
    parameter int PERF_W = CH_SCHED_PERF_W
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    conv_ch_scheduler_if.slave  bus
);
    ch_sched_state_e state_q;
    logic [CH_W-1:0] count_q;
    logic [CH_W-1:0] cur_ch_q;
    logic            in_flag_q;
    logic            wt_flag_q;
    logic            launch_q;
    logic            drain_q;
    logic            done_q;

    logic            in_flag_d;
    logic            wt_flag_d;
    logic            last_ch;
    logic            start_acc;
    logic            busy;

    // Sticky flags include this cycle's finished pulses so same-cycle arrivals advance at once.
    assign in_flag_d = in_flag_q | bus.inputs_finished_i;
    assign wt_flag_d = wt_flag_q | bus.weights_finished_i;
    assign last_ch   = (cur_ch_q == (count_q - CH_W'(1)));
    assign start_acc = (state_q == CS_IDLE) && bus.start_i && !bus.abort_i;
    assign busy      = (state_q != CS_IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= CS_IDLE;
            count_q   <= '0;
            cur_ch_q  <= '0;
            in_flag_q <= 1'b0;
            wt_flag_q <= 1'b0;
            launch_q  <= 1'b0;
            drain_q   <= 1'b0;
            done_q    <= 1'b0;
        end else if (bus.abort_i) begin
            state_q   <= CS_IDLE;
            cur_ch_q  <= '0;
            in_flag_q <= 1'b0;
            wt_flag_q <= 1'b0;
            launch_q  <= 1'b0;
            drain_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                CS_IDLE: begin
                    if (start_acc) begin
                        if (bus.cfg_num_ch_i != '0) begin
                            count_q  <= bus.cfg_num_ch_i;
                            cur_ch_q <= '0;
                            launch_q <= 1'b1;
                            state_q  <= CS_LAUNCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= CS_DONE;
                        end
                    end
                end
                CS_LAUNCH: begin
                    // Finished levels still high from the previous channel must not count here.
                    in_flag_q <= 1'b0;
                    wt_flag_q <= 1'b0;
                    state_q   <= CS_WAIT;
                end
                CS_WAIT: begin
                    in_flag_q <= in_flag_d;
                    wt_flag_q <= wt_flag_d;
                    if (in_flag_d && wt_flag_d) begin
                        state_q <= CS_NEXT;
                    end
                end
                CS_NEXT: begin
                    if (last_ch) begin
                        drain_q <= 1'b1;
                        state_q <= CS_DRAIN;
                    end else begin
                        cur_ch_q <= cur_ch_q + CH_W'(1);
                        launch_q <= 1'b1;
                        state_q  <= CS_LAUNCH;
                    end
                end
                CS_DRAIN: begin
                    if (bus.sa_drain_done_i) begin
                        drain_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= CS_DONE;
                    end
                end
                CS_DONE: begin
                    state_q <= CS_IDLE;
                end
                default: begin
                    state_q <= CS_IDLE;
                end
            endcase
        end
    end

    assign bus.inputs_start_o  = launch_q;
    assign bus.weights_start_o = launch_q;
    assign bus.current_ch_o    = cur_ch_q;
    assign bus.sa_drain_o      = drain_q;
    assign bus.done_o          = done_q;
    assign bus.busy_o          = busy;

`ifdef CH_SCHED_PERF_EN
    ch_sched_perf_cnt #(
        .W(PERF_W)
    ) u_perf (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .clr_i  (start_acc),
        .inc_i  (busy),
        .cnt_o  (bus.perf_cycles_o)
    );
`else
    assign bus.perf_cycles_o = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_conv_ch_scheduler.sv
// Randomized bench for conv_ch_scheduler: a feeder/SA stand-in drives the DUT and
// queues the expected start/drain/done events; a monitor pops and compares them.
module tb_conv_ch_scheduler;
    import conv_ch_scheduler_pkg::*;

    localparam int EV_START = 0;
    localparam int EV_DRAIN = 1;
    localparam int EV_DONE  = 2;
`ifdef CH_SCHED_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct {
        int kind;
        int ch;
        int cyc;
    } ev_t;

    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   layer_s = 0;
    bit   drain_prev = 1'b0;
    ev_t  exp_q[$];

    conv_ch_scheduler_if bus ();

    conv_ch_scheduler dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic push_ev(input int kind, input int ch, input int c);
        ev_t e;
        e.kind = kind;
        e.ch   = ch;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int kind, input int ch);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d ch %0d at cycle %0d, expected none",
                     kind, ch, cyc_cnt);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == EV_START) chk("event_channel", ch, e.ch);
            chk("event_cycle", cyc_cnt, e.cyc);
        end
    endtask

    // Monitor: every DUT-presented event must match the head of the expectation queue.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (bus.inputs_start_o || bus.weights_start_o) begin
                chk("start_pair", bus.inputs_start_o, bus.weights_start_o);
                pop_cmp(EV_START, int'(bus.current_ch_o));
            end
            if (bus.sa_drain_o && !drain_prev) pop_cmp(EV_DRAIN, 0);
            if (bus.done_o) begin
                chk("drain_low_at_done", bus.sa_drain_o, 0);
                pop_cmp(EV_DONE, 0);
            end
        end
        drain_prev = bus.sa_drain_o;
    end

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return bus.inputs_start_o;
            1:       return bus.sa_drain_o;
            default: return !bus.busy_o;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        int b = 0;
        while (!cond(which) && b < 1000) begin
            cyc();
            b++;
        end
        if (b >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: event never seen, expected within 1000 cycles", name);
        end
    endtask

    task automatic issue_start(input int n);
        bus.cfg_num_ch_i = 7'(n);
        bus.start_i      = 1'b1;
        layer_s          = cyc_cnt;
        if (n == 0) push_ev(EV_DONE, 0, layer_s + 1);
        else        push_ev(EV_START, 0, layer_s + 1);
        cyc();
        bus.start_i      = 1'b0;
        bus.cfg_num_ch_i = 7'($urandom);
    endtask

    // Feeder stand-in for one channel; also injects inputs the DUT must ignore.
    task automatic feed_ch(input int ch, input int n, input int di, input int dw, input bit ghost);
        int mx;
        mx = (di > dw) ? di : dw;
        wait_for(0, "feeder_start");
        bus.inputs_finished_i  = ghost;
        bus.weights_finished_i = ghost;
        for (int t = 1; t <= mx; t++) begin
            cyc();
            bus.inputs_finished_i  = (t == di);
            bus.weights_finished_i = (t == dw);
            bus.start_i            = ($urandom_range(0, 3) == 0);
            bus.sa_drain_done_i    = ($urandom_range(0, 3) == 0);
        end
        if (ch == n - 1) push_ev(EV_DRAIN, 0, cyc_cnt + 2);
        else             push_ev(EV_START, ch + 1, cyc_cnt + 2);
        cyc();
        bus.inputs_finished_i  = 1'b0;
        bus.weights_finished_i = 1'b0;
        bus.start_i            = 1'b0;
        bus.sa_drain_done_i    = 1'b0;
    endtask

    task automatic finish_layer(input int n);
        int dn;
        if (n == 0) begin
            dn = layer_s + 1;
        end else begin
            wait_for(1, "sa_drain");
            repeat ($urandom_range(0, 3)) cyc();
            bus.sa_drain_done_i = 1'b1;
            dn = cyc_cnt + 1;
            push_ev(EV_DONE, 0, dn);
            cyc();
            bus.sa_drain_done_i = 1'b0;
        end
        repeat (3) cyc();
        chk("busy_after_done", bus.busy_o, 0);
        chk("drain_after_done", bus.sa_drain_o, 0);
        if (n > 0) chk("ch_held_after_done", bus.current_ch_o, n - 1);
        chk("perf_cycles", bus.perf_cycles_o, PERF_EN ? (dn - layer_s) : 0);
    endtask

    task automatic run_layer(input int n, input int mode);
        int di, dw;
        bit gh;
        issue_start(n);
        for (int ch = 0; ch < n; ch++) begin
            case (mode)
                1: begin di = 5; dw = 9; gh = 1'b0; end
                2: begin
                    di = (ch == 0) ? 4 : 3;
                    dw = (ch == 0) ? 2 : 3;
                    gh = (ch == 1);
                end
                3: begin di = 1; dw = 1; gh = 1'b0; end
                default: begin
                    di = $urandom_range(1, 6);
                    dw = $urandom_range(1, 6);
                    gh = 1'(($urandom_range(0, 1)));
                end
            endcase
            feed_ch(ch, n, di, dw, gh);
        end
        finish_layer(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i            = 1'b0;
        bus.abort_i            = 1'b0;
        bus.cfg_num_ch_i       = '0;
        bus.inputs_finished_i  = 1'b0;
        bus.weights_finished_i = 1'b0;
        bus.sa_drain_done_i    = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_in_start", bus.inputs_start_o, 0);
        chk("rst_wt_start", bus.weights_start_o, 0);
        chk("rst_drain", bus.sa_drain_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_ch", bus.current_ch_o, 0);
        chk("rst_perf", bus.perf_cycles_o, 0);
        i_rstn = 1'b1;
        cyc();
        cyc();

        run_layer(3, 1);
        run_layer(2, 2);
        run_layer(0, 0);
        run_layer(1, 0);

        // Abort in WAIT of channel 1, with a coincident start.
        issue_start(4);
        feed_ch(0, 4, 2, 3, 1'b0);
        wait_for(0, "ch1_start");
        cyc();
        cyc();
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        cyc();
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        chk("abort_busy", bus.busy_o, 0);
        chk("abort_ch", bus.current_ch_o, 0);
        chk("abort_in_start", bus.inputs_start_o, 0);
        chk("abort_done", bus.done_o, 0);
        // Abort also beats a start issued from IDLE.
        bus.cfg_num_ch_i = 7'd3;
        bus.start_i      = 1'b1;
        bus.abort_i      = 1'b1;
        cyc();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("abort_over_start", bus.busy_o, 0);
        repeat (5) cyc();
        chk("abort_queue_empty", exp_q.size(), 0);
        run_layer(3, 0);

        for (int k = 0; k < 6; k++) run_layer($urandom_range(1, 5), 0);
        run_layer(127, 3);

        // Asynchronous reset in the middle of channel 1.
        issue_start(3);
        feed_ch(0, 3, 1, 2, 1'b0);
        wait_for(0, "ch1_start_rst");
        chk("pre_rst_ch", bus.current_ch_o, 1);
        #2 i_rstn = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_ch", bus.current_ch_o, 0);
        chk("arst_in_start", bus.inputs_start_o, 0);
        exp_q.delete();
        cyc();
        cyc();
        i_rstn = 1'b1;
        cyc();
        run_layer(2, 0);

        repeat (3) cyc();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
